// File: rtl/wot_pkg.sv
// rtl/wot_pkg.sv - shared constants and types for the bullet drawing stage
package wot_pkg;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  // Tank facing encoding
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Tank box is TANK_SHORT wide x TANK_LONG tall when facing up/down,
  // and rotated (TANK_LONG x TANK_SHORT) when facing left/right.
  localparam int TANK_SHORT = 48;
  localparam int TANK_LONG  = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLY      = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/draw_bullet_rise_detect.sv
// rtl/draw_bullet_rise_detect.sv - registered rising-edge detector
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  // Remember the previous level and emit a one-cycle registered pulse on 0->1
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/draw_bullet.sv
// rtl/draw_bullet.sv - single-bullet FSM and overlay onto the pixel stream
module draw_bullet #(
  parameter int          SCREEN_W        = wot_pkg::SCREEN_W,
  parameter int          SCREEN_H        = wot_pkg::SCREEN_H,
  parameter int          BULLET_SIZE     = 4,
  parameter int          SPEED           = 4,
  parameter int          COOLDOWN_FRAMES = 16,
  parameter logic [11:0] BULLET_COLOR    = 12'hF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [9:0]  posX_tank,
  input  logic [9:0]  posY_tank,
  input  logic [1:0]  direction,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        bullet_active,
  output logic [9:0]  bulletX,
  output logic [9:0]  bulletY
);

  import wot_pkg::*;

  localparam int               CNT_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_FRAMES);
  // Spawn offsets centre the bullet across the barrel and put it at the muzzle end
  localparam logic [9:0]       OFF_MID  = 10'((TANK_SHORT - BULLET_SIZE) / 2);
  localparam logic [9:0]       OFF_FAR  = 10'(TANK_LONG - BULLET_SIZE);
  localparam logic [9:0]       STEP     = 10'(SPEED);
  localparam logic [10:0]      STEP_W   = 11'(SPEED);
  localparam logic [10:0]      X_MAX    = 11'(SCREEN_W - BULLET_SIZE);
  localparam logic [10:0]      Y_MAX    = 11'(SCREEN_H - BULLET_SIZE);
  localparam logic [10:0]      SIZE_W   = 11'(BULLET_SIZE);

  state_t            state;
  state_t            state_next;
  logic              fire_evt;
  logic              tick;
  logic [1:0]        dir_q;
  logic [CNT_W-1:0]  cnt;
  logic [9:0]        spawn_x;
  logic [9:0]        spawn_y;
  logic              blocked;
  logic              draw;
  logic [10:0]       bx_w;
  logic [10:0]       by_w;

  assign bx_w = {1'b0, bulletX};
  assign by_w = {1'b0, bulletY};

  rise_detect u_fire_edge (
    .clk   (clk),
    .rst   (rst),
    .level (fire),
    .pulse (fire_evt)
  );

  rise_detect u_frame_edge (
    .clk   (clk),
    .rst   (rst),
    .level (vblnk_in),
    .pulse (tick)
  );

  // Spawn point at the muzzle for the current tank facing
  always_comb begin
    spawn_x = posX_tank;
    spawn_y = posY_tank;
    case (direction)
      DIR_UP:    spawn_x = posX_tank + OFF_MID;
      DIR_DOWN:  begin
        spawn_x = posX_tank + OFF_MID;
        spawn_y = posY_tank + OFF_FAR;
      end
      DIR_LEFT:  spawn_y = posY_tank + OFF_MID;
      DIR_RIGHT: begin
        spawn_x = posX_tank + OFF_FAR;
        spawn_y = posY_tank + OFF_MID;
      end
      default:   ;
    endcase
  end

  // Would the next step leave the screen? Compares only, so up/left never wrap
  always_comb begin
    blocked = 1'b0;
    case (dir_q)
      DIR_UP:    blocked = by_w < STEP_W;
      DIR_DOWN:  blocked = (by_w + STEP_W) > Y_MAX;
      DIR_LEFT:  blocked = bx_w < STEP_W;
      DIR_RIGHT: blocked = (bx_w + STEP_W) > X_MAX;
      default:   ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic; fire events outside IDLE are simply dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (fire_evt) state_next = FLY;
      FLY:      if (tick && blocked) state_next = COOLDOWN;
      COOLDOWN: if (cnt == '0 || (tick && cnt == CNT_W'(1))) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bullet_active = (state == FLY);
  end

  // Bullet position, latched facing and cooldown counter; moves only on frame ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      bulletX <= '0;
      bulletY <= '0;
      dir_q   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_evt) begin
            dir_q   <= direction;
            bulletX <= spawn_x;
            bulletY <= spawn_y;
          end
        end
        FLY: begin
          if (tick) begin
            if (blocked) begin
              cnt <= CNT_LOAD;
            end else begin
              case (dir_q)
                DIR_UP:    bulletY <= bulletY - STEP;
                DIR_DOWN:  bulletY <= bulletY + STEP;
                DIR_LEFT:  bulletX <= bulletX - STEP;
                DIR_RIGHT: bulletX <= bulletX + STEP;
                default:   ;
              endcase
            end
          end
        end
        COOLDOWN: begin
          if (tick && cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Current pixel lies inside the flying bullet's square and is visible
  always_comb begin
    draw = (state == FLY) && !hblnk_in && !vblnk_in &&
           (hcount_in >= bx_w) && (hcount_in < bx_w + SIZE_W) &&
           ({1'b0, vcount_in} >= by_w) && ({1'b0, vcount_in} < by_w + SIZE_W);
  end

  // One-cycle pipeline stage for timing and the composited pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= draw ? BULLET_COLOR : rgb_in;
    end
  end

endmodule

// File: tb/tb_draw_bullet.sv
// tb/tb_draw_bullet.sv - directed self-checking bench for draw_bullet
module tb_draw_bullet;

  logic        clk;
  logic        rst;
  logic        fire;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        hblnk_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic [9:0]  posX_tank;
  logic [9:0]  posY_tank;
  logic [1:0]  direction;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        hblnk_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;
  logic        bullet_active;
  logic [9:0]  bulletX;
  logic [9:0]  bulletY;

  int checks = 0;
  int errors = 0;

  draw_bullet dut (
    .clk           (clk),
    .rst           (rst),
    .fire          (fire),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .hblnk_in      (hblnk_in),
    .vblnk_in      (vblnk_in),
    .rgb_in        (rgb_in),
    .posX_tank     (posX_tank),
    .posY_tank     (posY_tank),
    .direction     (direction),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .hblnk_out     (hblnk_out),
    .vblnk_out     (vblnk_out),
    .rgb_out       (rgb_out),
    .bullet_active (bullet_active),
    .bulletX       (bulletX),
    .bulletY       (bulletY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One vblnk rising edge; movement is visible when the task returns
  task automatic frame();
    vblnk_in = 1'b1;
    cyc(1);
    vblnk_in = 1'b0;
    cyc(2);
  endtask

  // Single-cycle fire request; a spawn is visible when the task returns
  task automatic fire_pulse();
    fire = 1'b1;
    cyc(1);
    fire = 1'b0;
    cyc(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; fire = 1'b0;
    hcount_in = 11'd7; vcount_in = 10'd9;
    hsync_in = 1'b1; vsync_in = 1'b1; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = 12'h5A5;
    posX_tank = 10'd100; posY_tank = 10'd200; direction = 2'd3;
    cyc(2);
    check("rst_rgb", 32'(rgb_out), 32'h0);
    check("rst_hcount", 32'(hcount_out), 32'd0);
    check("rst_hsync", 32'(hsync_out), 32'd0);
    check("rst_active", 32'(bullet_active), 32'd0);
    check("rst_bx", 32'(bulletX), 32'd0);
    check("rst_by", 32'(bulletY), 32'd0);
    rst = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    hcount_in = 11'd123; vcount_in = 10'd45;
    cyc(1);
    check("lat_hcount", 32'(hcount_out), 32'd123);
    check("lat_vcount", 32'(vcount_out), 32'd45);
    check("lat_rgb", 32'(rgb_out), 32'h5A5);

    // Right-facing shot from (100,200)
    fire_pulse();
    check("r_active", 32'(bullet_active), 32'd1);
    check("r_spawn_x", 32'(bulletX), 32'd160);
    check("r_spawn_y", 32'(bulletY), 32'd222);
    frame();
    check("r_move1", 32'(bulletX), 32'd164);
    frame();
    check("r_move2", 32'(bulletX), 32'd168);
    check("r_move2_y", 32'(bulletY), 32'd222);

    // Up-facing shot hitting the top edge, then cooldown
    do_reset();
    posX_tank = 10'd100; posY_tank = 10'd8; direction = 2'd0;
    fire_pulse();
    check("u_spawn_x", 32'(bulletX), 32'd122);
    check("u_spawn_y", 32'(bulletY), 32'd8);
    frame();
    check("u_y4", 32'(bulletY), 32'd4);
    frame();
    check("u_y0", 32'(bulletY), 32'd0);
    check("u_y0_active", 32'(bullet_active), 32'd1);
    frame();
    check("u_exit_y", 32'(bulletY), 32'd0);
    check("u_exit_active", 32'(bullet_active), 32'd0);
    repeat (9) frame();
    fire_pulse();
    check("cd_fire10_ignored", 32'(bullet_active), 32'd0);
    repeat (6) frame();
    fire_pulse();
    check("cd_fire15_ignored", 32'(bullet_active), 32'd0);
    fire = 1'b1;
    cyc(2);
    frame();
    cyc(3);
    check("cd_no_queue_held", 32'(bullet_active), 32'd0);
    fire = 1'b0;
    cyc(1);
    fire_pulse();
    check("cd_refire_active", 32'(bullet_active), 32'd1);
    check("cd_refire_y", 32'(bulletY), 32'd8);
    check("cd_refire_x", 32'(bulletX), 32'd122);

    // Fire held across several frames; direction is latched at spawn
    do_reset();
    posX_tank = 10'd100; posY_tank = 10'd200; direction = 2'd1;
    fire = 1'b1;
    cyc(2);
    check("h_spawn_y", 32'(bulletY), 32'd260);
    repeat (5) frame();
    check("h_y_after5", 32'(bulletY), 32'd280);
    check("h_active", 32'(bullet_active), 32'd1);
    fire = 1'b0;
    direction = 2'd3;
    cyc(1);
    fire_pulse();
    check("h_second_fire_y", 32'(bulletY), 32'd280);
    check("h_second_fire_x", 32'(bulletX), 32'd122);
    frame();
    check("h_latched_dir_y", 32'(bulletY), 32'd284);
    check("h_latched_dir_x", 32'(bulletX), 32'd122);

    // Fire and frame tick in the same cycle: spawn only
    do_reset();
    posX_tank = 10'd100; posY_tank = 10'd200; direction = 2'd3;
    fire = 1'b1; vblnk_in = 1'b1;
    cyc(1);
    fire = 1'b0; vblnk_in = 1'b0;
    cyc(2);
    check("co_spawn_x", 32'(bulletX), 32'd160);
    check("co_active", 32'(bullet_active), 32'd1);
    frame();
    check("co_move_x", 32'(bulletX), 32'd164);

    // Pixel overlay around a bullet at (300,300)
    do_reset();
    posX_tank = 10'd278; posY_tank = 10'd300; direction = 2'd0;
    fire_pulse();
    check("px_bx", 32'(bulletX), 32'd300);
    check("px_by", 32'(bulletY), 32'd300);
    hcount_in = 11'd302; vcount_in = 10'd301; rgb_in = 12'h0AB;
    cyc(1);
    check("px_inside", 32'(rgb_out), 32'hF00);
    check("px_hcount", 32'(hcount_out), 32'd302);
    hblnk_in = 1'b1;
    cyc(1);
    check("px_hblnk", 32'(rgb_out), 32'h0AB);
    check("px_hblnk_out", 32'(hblnk_out), 32'd1);
    hblnk_in = 1'b0;
    hcount_in = 11'd304;
    cyc(1);
    check("px_right_edge", 32'(rgb_out), 32'h0AB);
    hcount_in = 11'd300; vcount_in = 10'd303;
    cyc(1);
    check("px_corner", 32'(rgb_out), 32'hF00);
    vcount_in = 10'd304;
    cyc(1);
    check("px_bottom_edge", 32'(rgb_out), 32'h0AB);
    hcount_in = 11'd302; vcount_in = 10'd301;
    rst = 1'b1;
    cyc(1);
    check("px_rst_rgb", 32'(rgb_out), 32'h0);
    check("px_rst_active", 32'(bullet_active), 32'd0);
    rst = 1'b0;
    cyc(1);
    check("px_after_rst", 32'(rgb_out), 32'h0AB);
    check("px_after_rst_bx", 32'(bulletX), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_bullet.md
DRAW_BULLET -- requirements
Module: draw_bullet

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- SCREEN_W, 800, visible width in px
- SCREEN_H, 600, visible height in px
- BULLET_SIZE, 4, square bullet edge in px
- SPEED, 4, px moved per frame
- COOLDOWN_FRAMES, 16, frames before the next shot
- BULLET_COLOR, 12'hF00, bullet pixel colour
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, pixel clock
- rst, in, 1, reset: synchronous, active-high
- fire, in, 1, fire request level
- hcount_in, in, 11, horizontal counter
- vcount_in, in, 10, vertical counter
- hsync_in, vsync_in, hblnk_in, vblnk_in, in, 1 each, timing signals
- rgb_in, in, 12, upstream pixel from the tank stage
- posX_tank, posY_tank, in, 10 each, tank top-left corner
- direction, in, 2, tank facing
- hcount_out, vcount_out, out, 11/10, delayed counters
- hsync_out, vsync_out, hblnk_out, vblnk_out, out, 1 each, delayed timing
- rgb_out, out, 12, composited pixel
- bullet_active, out, 1, high while in FLY
- bulletX, bulletY, out, 10 each, bullet top-left corner

Function
REQ-003 Direction encoding SHALL be 0 up, 1 down, 2 left, 3 right; tank box SHALL be 48x64 for directions 0/1 and 64x48 for directions 2/3.
REQ-004 Frame tick SHALL be a one-cycle pulse on the registered rising edge of vblnk_in.
REQ-005 Fire event SHALL be the registered rising edge of fire; a held level SHALL NOT refire.
REQ-006 FSM states SHALL be IDLE, FLY and COOLDOWN.
REQ-007 In IDLE, a fire event SHALL latch direction, load the spawn position and enter FLY on the next cycle.
REQ-008 Spawn positions SHALL be:
- up: (posX+22, posY)
- down: (posX+22, posY+60)
- left: (posX, posY+22)
- right: (posX+60, posY+22)
REQ-009 In FLY, each frame tick SHALL move the bullet SPEED px in the latched direction.
REQ-010 In FLY, if the next move would leave [0, SCREEN_W-BULLET_SIZE] x [0, SCREEN_H-BULLET_SIZE], the position SHALL NOT change; the FSM SHALL enter COOLDOWN and load the counter with COOLDOWN_FRAMES.
REQ-011 The bound check in REQ-010 SHALL use compares only, with no underflow: up exits when bulletY < SPEED; left exits when bulletX < SPEED.
REQ-012 In COOLDOWN, each frame tick SHALL decrement the counter; reaching 0 SHALL return the FSM to IDLE.
REQ-013 Fire events outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-014 If a fire event and a frame tick coincide in IDLE, the block SHALL spawn and SHALL NOT advance in that cycle.
REQ-015 Position SHALL change only on frame ticks after spawn, so a bullet never tears mid-frame.
REQ-016 A pixel SHALL be drawn with BULLET_COLOR when all of the following hold; otherwise rgb_out SHALL be rgb_in:
- state is FLY
- bulletX <= hcount_in < bulletX+BULLET_SIZE
- bulletY <= vcount_in < bulletY+BULLET_SIZE
- hblnk_in = 0 and vblnk_in = 0
REQ-017 All timing, counter and rgb outputs SHALL have a latency of exactly 1 clk.
REQ-018 bullet_active, bulletX and bulletY SHALL be registered state, valid every cycle.

Reset
REQ-019 On rst, state SHALL be IDLE and the cooldown counter 0.
REQ-020 On rst, every output, the edge-detect registers and bulletX/bulletY SHALL be 0.
REQ-021 rst asserted during FLY or COOLDOWN SHALL abort to IDLE with no bullet drawn on the following cycle.

Structure
REQ-022 Package wot_pkg SHALL hold the direction encoding constants, SCREEN_W/SCREEN_H, the tank box dimensions and the FSM state typedef.
REQ-023 One sub-module, rise_detect, SHALL be instantiated twice: once for fire and once for vblnk_in.

Verification
REQ-024 Bench SHALL cover these directed scenarios:
- Tank at (100,200), dir 3, fire pulse -> bulletX=160, bulletY=222; +4 px per frame tick.
- Tank at (100,8), dir 0, fire -> spawn y=8; tick -> y=4; tick -> y=0; next tick -> COOLDOWN at y=0, bullet_active=0.
- fire held high for 5 frames in IDLE -> exactly one spawn; second fire during FLY -> no effect.
- COOLDOWN entered; fire at tick 10 ignored; after 16 ticks IDLE; next fire spawns.
- Fire coincident with vblnk rise -> spawn position unchanged that cycle.
- Bullet at (300,300) in FLY: hcount=302, vcount=301, unblanked -> rgb_out=F00 one cycle later; hblnk=1 -> rgb_in passed through; rst mid-FLY -> rgb_out=0, then pass-through.
